// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave that receives 8-byte command frames (header, payload, XOR check)
// and atomically publishes the waveform, frequency and amplitude words on a good frame.
`timescale 1ns/1ps
module spi_frame_rx #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk,
   input  logic        cs_n,
   input  logic        mosi,
   output logic        miso,
   output logic [7:0]  pic_dat,
   output logic [23:0] fre_dat,
   output logic [15:0] amp_dat,
   output logic        SPI_OK,
   output logic        frame_stb,
   output logic        frame_err
);

   typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CHK, DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, cs_prev_q;
   logic [SYNC_STAGES:0]   ready_q;
   state_t                 state_q, state_d;
   logic [2:0]             bit_cnt_q, byte_cnt_q;
   logic [6:0]             shift_q;
   logic [47:0]            shadow_q;
   logic [7:0]             last_q, tx_q;
   logic [7:0]             pic_q;
   logic [23:0]            fre_q;
   logic [15:0]            amp_q;
   logic                   ok_q, stb_q, err_q;
   logic                   stb_d, err_d, commit;

   logic       sclk_s, cs_s, mosi_s, ready;
   logic       sclk_rise, sclk_fall, cs_rise, cs_fall, byte_done;
   logic [7:0] rx_byte, chk_calc;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         ready_q     <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_prev_q <= sclk_s;
         cs_prev_q   <= cs_s;
         ready_q     <= {ready_q[SYNC_STAGES-1:0], 1'b1};
      end
   end

   // Edges are suppressed until the chains have flushed their reset values, so a
   // cs_n that was already low at reset release cannot look like a fresh falling edge.
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ready     = ready_q[SYNC_STAGES];
   assign sclk_rise = ready &  sclk_s & ~sclk_prev_q;
   assign sclk_fall = ready & ~sclk_s &  sclk_prev_q;
   assign cs_rise   = ready &  cs_s   & ~cs_prev_q;
   assign cs_fall   = ready & ~cs_s   &  cs_prev_q;
   assign rx_byte   = {shift_q, mosi_s};
   assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);

   always_comb begin
      chk_calc = '0;
      for (int i = 0; i < 6; i++) chk_calc = chk_calc ^ shadow_q[8*i +: 8];
   end

   always_comb begin
      state_d = state_q;
      stb_d   = 1'b0;
      err_d   = 1'b0;
      commit  = 1'b0;
      if (cs_rise) begin
         state_d = IDLE;
         if ((state_q == HDR && bit_cnt_q != 3'd0) || state_q == PAYLOAD || state_q == CHK)
            err_d = 1'b1;
      end else begin
         case (state_q)
            IDLE:    if (cs_fall) state_d = HDR;
            HDR: begin
               if (byte_done) begin
                  if (rx_byte == HEADER) begin
                     state_d = PAYLOAD;
                  end else begin
                     state_d = DONE;
                     err_d   = 1'b1;
                  end
               end
            end
            PAYLOAD: if (byte_done && byte_cnt_q == 3'd5) state_d = CHK;
            CHK: begin
               if (byte_done) begin
                  state_d = DONE;
                  if (rx_byte == chk_calc) begin
                     commit = 1'b1;
                     stb_d  = 1'b1;
                  end else begin
                     err_d  = 1'b1;
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   // Bit/byte datapath keeps running in DONE so miso still echoes the ignored bytes.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         shadow_q   <= '0;
         last_q     <= '0;
         tx_q       <= '0;
      end else if (cs_rise) begin
         bit_cnt_q <= '0;
      end else if (state_q == IDLE) begin
         if (cs_fall) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            tx_q       <= last_q;
         end
      end else begin
         if (sclk_rise) begin
            shift_q   <= rx_byte[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) begin
               last_q <= rx_byte;
               if (state_q == PAYLOAD) begin
                  shadow_q   <= {shadow_q[39:0], rx_byte};
                  byte_cnt_q <= byte_cnt_q + 3'd1;
               end
            end
         end
         if (sclk_fall)
            tx_q <= (bit_cnt_q == 3'd0) ? last_q : {tx_q[6:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pic_q   <= '0;
         fre_q   <= '0;
         amp_q   <= '0;
         ok_q    <= 1'b0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
         if (commit) begin
            pic_q <= shadow_q[47:40];
            fre_q <= shadow_q[39:16];
            amp_q <= shadow_q[15:0];
            ok_q  <= 1'b1;
         end
      end
   end

   assign miso      = tx_q[7] & ~cs_s;
   assign pic_dat   = pic_q;
   assign fre_dat   = fre_q;
   assign amp_dat   = amp_q;
   assign SPI_OK    = ok_q;
   assign frame_stb = stb_q;
   assign frame_err = err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Self-checking bench for spi_frame_rx: directed and random frames driven as an
// SPI mode-0 master, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_frame_rx;

   localparam int         SYNC = 2;
   localparam logic [7:0] HDR  = 8'hA5;
   localparam int         HALF = 60;

   logic        clk = 1'b0;
   logic        rst, sclk, cs_n, mosi;
   logic        miso, SPI_OK, frame_stb, frame_err;
   logic [7:0]  pic_dat;
   logic [23:0] fre_dat;
   logic [15:0] amp_dat;

   spi_frame_rx #(.HEADER(HDR), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .miso(miso), .pic_dat(pic_dat), .fre_dat(fre_dat), .amp_dat(amp_dat),
      .SPI_OK(SPI_OK), .frame_stb(frame_stb), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0, stb_cnt = 0, err_cnt = 0, stb_cycle = 0, bad_atomic = 0;
   int last_rise_cycle = 0;
   logic [47:0] prev_out = '0;
   logic        prev_rst = 1'b1;

   logic [7:0]  exp_pic = '0, prev_byte = '0;
   logic [23:0] exp_fre = '0;
   logic [15:0] exp_amp = '0;
   logic        exp_ok = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_stb) begin
            stb_cnt++;
            stb_cycle = cyc;
         end
         if (frame_err) err_cnt++;
         if (!prev_rst && {pic_dat, fre_dat, amp_dat} !== prev_out && !frame_stb) bad_atomic++;
      end
      prev_out = {pic_dat, fre_dat, amp_dat};
      prev_rst = rst;
   end

   function automatic logic [63:0] make_frame(input logic [7:0] h, input logic [7:0] p,
                                              input logic [23:0] fr, input logic [15:0] am,
                                              input logic [7:0] delta);
      logic [7:0] c;
      c = p ^ fr[23:16] ^ fr[15:8] ^ fr[7:0] ^ am[15:8] ^ am[7:0] ^ delta;
      return {h, p, fr, am, c};
   endfunction

   function automatic logic [63:0] rand_valid();
      return make_frame(HDR, 8'($urandom), 24'($urandom), 16'($urandom), 8'h00);
   endfunction

   // Frame-level outcome: how many bits arrived and whether header/checksum hold.
   task automatic model_frame(input logic [63:0] f, input int nbits, output int es, output int ee);
      logic [7:0] x;
      x  = f[55:48] ^ f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8];
      es = 0;
      ee = 0;
      if (nbits == 0) begin
         ee = 0;
      end else if (nbits >= 8 && f[63:56] != HDR) begin
         ee = 1;
      end else if (nbits < 64) begin
         ee = 1;
      end else if (x == f[7:0]) begin
         es = 1;
         exp_pic = f[55:48];
         exp_fre = f[47:24];
         exp_amp = f[23:8];
         exp_ok  = 1'b1;
      end else begin
         ee = 1;
      end
   endtask

   task automatic spi_xfer(input logic [63:0] f, input int nbits, input bit lower_cs,
                           input bit raise_cs, input bit chk_miso);
      logic [7:0] cap, b;
      cap = '0;
      if (lower_cs) begin
         cs_n = 1'b0;
         #(HALF);
      end
      for (int i = 0; i < nbits; i++) begin
         mosi = f[63-i];
         #(HALF);
         cap = {cap[6:0], miso};
         sclk = 1'b1;
         last_rise_cycle = cyc;
         #(HALF);
         sclk = 1'b0;
         if (i % 8 == 7) begin
            b = 8'(f >> (56 - 8 * (i / 8)));
            if (chk_miso) begin
               check("miso_echo", cap, prev_byte);
               prev_byte = b;
            end
         end
      end
      mosi = 1'b0;
      #(HALF);
      if (raise_cs) cs_n = 1'b1;
   endtask

   task automatic run_frame(input string name, input logic [63:0] f, input int nbits, input int gap_ns);
      int s0, e0, es, ee;
      s0 = stb_cnt;
      e0 = err_cnt;
      model_frame(f, nbits, es, ee);
      spi_xfer(f, nbits, 1'b1, 1'b1, 1'b1);
      #(gap_ns);
      @(negedge clk);
      #1;
      check({name, "_stb"}, stb_cnt - s0, es);
      check({name, "_err"}, err_cnt - e0, ee);
      check({name, "_pic"}, pic_dat, exp_pic);
      check({name, "_fre"}, fre_dat, exp_fre);
      check({name, "_amp"}, amp_dat, exp_amp);
      check({name, "_ok"}, SPI_OK, exp_ok);
      if (es == 1) check({name, "_latency"}, stb_cycle - last_rise_cycle, SYNC + 1);
      $display("frame %-12s data=%016h bits=%0d stb=%0d err=%0d pic=%02h fre=%06h amp=%04h ok=%0b",
               name, f, nbits, stb_cnt - s0, err_cnt - e0, pic_dat, fre_dat, amp_dat, SPI_OK);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_pic"}, pic_dat, 0);
      check({name, "_fre"}, fre_dat, 0);
      check({name, "_amp"}, amp_dat, 0);
      check({name, "_ok"}, SPI_OK, 0);
      check({name, "_stb"}, frame_stb, 0);
      check({name, "_err"}, frame_err, 0);
      check({name, "_miso"}, miso, 0);
   endtask

   initial begin
      int s0, e0, kind, nb;
      logic [7:0]  h;
      logic [63:0] f;

      rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check_reset_outputs("reset");

      // cs_n already low at reset release must not open a frame
      cs_n = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      s0 = stb_cnt;
      e0 = err_cnt;
      spi_xfer(64'hA502001000800092, 64, 1'b0, 1'b1, 1'b0);
      #120;
      @(negedge clk);
      #1;
      check("stale_cs_stb", stb_cnt - s0, 0);
      check("stale_cs_err", err_cnt - e0, 0);
      check("stale_cs_ok", SPI_OK, 0);
      check("stale_cs_pic", pic_dat, 0);
      $display("frame %-12s no edge after reset, stb=%0d err=%0d", "stale_cs", stb_cnt - s0, err_cnt - e0);

      run_frame("good", 64'hA502001000800092, 64, 120);
      run_frame("bad_chk", 64'hA502001000800093, 64, 120);
      run_frame("bad_hdr", 64'h5A02001000800092, 64, 120);
      run_frame("abort", rand_valid(), 28, 120);
      run_frame("after_abort", rand_valid(), 64, 120);
      run_frame("b2b_1", rand_valid(), 64, 20);
      run_frame("b2b_2", rand_valid(), 64, 120);

      for (int n = 0; n < 20; n++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: begin f = rand_valid(); nb = 64; end
            1: begin f = make_frame(HDR, 8'($urandom), 24'($urandom), 16'($urandom),
                                    8'($urandom_range(1, 255))); nb = 64; end
            2: begin
               h = 8'($urandom);
               if (h == HDR) h = h ^ 8'h01;
               f = make_frame(h, 8'($urandom), 24'($urandom), 16'($urandom), 8'h00);
               nb = 64;
            end
            default: begin f = rand_valid(); nb = int'($urandom_range(0, 63)); end
         endcase
         run_frame("random", f, nb, 120);
      end

      // reset in the middle of the payload, then a clean frame
      run_frame("pre_reset", rand_valid(), 64, 120);
      cs_n = 1'b0;
      #(HALF);
      spi_xfer(rand_valid(), 24, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("mid_reset");
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      exp_pic = '0; exp_fre = '0; exp_amp = '0; exp_ok = 1'b0; prev_byte = '0;
      repeat (6) @(negedge clk);
      run_frame("post_reset", rand_valid(), 64, 120);

      check("atomic_update", bad_atomic, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_frame_rx.md
SPI_FRAME_RX -- requirements
Module: spi_frame_rx

Interface
REQ-001 Parameter HEADER, default 8'hA5, required value of the first byte of every frame.
REQ-002 Parameter SYNC_STAGES, default 2, number of flip-flops in each synchronizer for sclk, cs_n and mosi; legal range 2..3.
REQ-003 clk  input  1  system clock (12 MHz); all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sclk  input  1  SPI clock from the STM32 master; mode 0 (CPOL=0, CPHA=0); asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active-low; asynchronous.
REQ-007 mosi  input  1  SPI data in, MSB first; asynchronous.
REQ-008 miso  output  1  echo of the previously completed byte, MSB first.
REQ-009 pic_dat  output  8  waveform select (1=square, 2=sine, 3=triangle; other values passed through unchecked).
REQ-010 fre_dat  output  24  frequency word.
REQ-011 amp_dat  output  16  amplitude word.
REQ-012 SPI_OK  output  1  sticky flag: at least one valid frame has been accepted since reset.
REQ-013 frame_stb  output  1  one-clk pulse when the outputs are updated.
REQ-014 frame_err  output  1  one-clk pulse when a frame is rejected.

Function
REQ-015 sclk, cs_n and mosi SHALL each pass through SYNC_STAGES flip-flops; edges SHALL be detected on the synchronized sclk only.
REQ-016 The master's sclk frequency SHALL be at most clk/8; behaviour above this rate is undefined.
REQ-017 A frame SHALL be 8 bytes, MSB first: HEADER, pic, fre[23:16], fre[15:8], fre[7:0], amp[15:8], amp[7:0], CHK.
REQ-018 CHK SHALL equal the XOR of the six payload bytes.
REQ-019 The FSM SHALL have the states IDLE, HDR, PAYLOAD, CHK and DONE.
REQ-020 IDLE -> HDR on a synchronized cs_n falling edge; the bit and byte counters SHALL be cleared on entry to HDR.
REQ-021 mosi SHALL be sampled on each synchronized sclk rising edge; a byte completes at the 8th sample, and the bit counter SHALL then wrap 7 -> 0.
REQ-022 HDR: if the completed byte equals HEADER, go to PAYLOAD; otherwise go to DONE and pulse frame_err.
REQ-023 PAYLOAD: the six bytes SHALL be stored in shadow registers; after the 6th byte, go to CHK.
REQ-024 CHK: on a match, copy the shadows to pic_dat/fre_dat/amp_dat in one clk, pulse frame_stb, set SPI_OK and go to DONE.
REQ-025 CHK: on a mismatch, leave the outputs unchanged, pulse frame_err and go to DONE.
REQ-026 The output update SHALL occur exactly 1 clk after the clk in which the 8th CHK bit is sampled.
REQ-027 pic_dat, fre_dat and amp_dat SHALL change only together (atomic update) and SHALL otherwise hold.
REQ-028 DONE: further bytes SHALL be ignored until cs_n rises.
REQ-029 A synchronized cs_n rising edge in any state SHALL return the FSM to IDLE.
REQ-030 If cs_n rises in HDR, PAYLOAD or CHK, the partial frame SHALL be discarded and frame_err SHALL pulse once; with zero bits received, no pulse.
REQ-031 miso SHALL shift out the last completed byte on each synchronized sclk falling edge, and SHALL drive 0 while cs_n is high.
REQ-032 A cs_n falling edge in the same clk as a cs_n rising edge cannot occur after synchronization; back-to-back frames need cs_n high for at least 2 clk.

Reset
REQ-033 While rst=1, pic_dat, fre_dat, amp_dat, SPI_OK, frame_stb, frame_err and miso SHALL be 0, and the FSM SHALL be in IDLE.
REQ-034 A frame in progress when rst asserts SHALL be abandoned.
REQ-035 After rst releases, a cs_n already low SHALL NOT start a frame; a fresh falling edge is required.
REQ-036 Synchronizer flip-flops SHALL be reset to idle levels: sclk=0, cs_n=1, mosi=0.

Verification
REQ-037 Frame A5 02 00 10 00 80 00 92 -> 1 clk after the last bit: pic_dat=02, fre_dat=001000, amp_dat=8000; frame_stb pulses once; SPI_OK=1.
REQ-038 Same frame with CHK=93 -> outputs hold their prior values, frame_err pulses once, SPI_OK unchanged.
REQ-039 Header 5A -> frame_err pulses; the remaining 7 bytes are ignored; no frame_stb.
REQ-040 cs_n rises after 3 bytes + 4 bits -> frame_err pulses once, FSM returns to IDLE, and the next valid frame is accepted.
REQ-041 rst asserted mid-PAYLOAD, then a valid frame sent -> all outputs 0 during rst, then the new values and SPI_OK=1 after the frame.
REQ-042 Two valid frames back-to-back with 2 clk of cs_n high -> two frame_stb pulses; miso during byte n+1 equals byte n.
